// File: rtl/reg_share_seq.sv
// -----------------------------------------------------------------------------
// reg_share_seq
//   A single WIDTH-bit storage register shared by two requesters.
//   Each transfer takes three cycles:
//     IDLE    : a request is sampled, the winner is arbitrated, and the winner's
//               data is latched into an internal hold register.
//     CAPTURE : master phase, one cycle.
//     COMMIT  : slave phase, one cycle. The winner's ack is high here.
//               On the edge that leaves COMMIT, hold is copied to Q and the
//               transfer counter increments.
//
// Handshake: a requester raises reqN and keeps it high until its ackN has been
//   high for one cycle. Requests are sampled only in IDLE and are never queued.
//   Dropping reqN after the sampling edge does not abort the transfer. Data is
//   read only at the sampling edge.
//
// Configuration macro: RR_FAIRNESS_EN
//   defined   : a tie goes to the requester that did not own the last commit.
//   undefined : a tie always goes to requester 0.
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   req0/d0   request and data from requester 0
//   req1/d1   request and data from requester 1
//   ack0/ack1 one-cycle transfer-complete strobes
//   busy      high while in CAPTURE or COMMIT
//   owner     requester of the current or most recent transfer
//   Q/Qnot    shared register and its complement
//   xfer_cnt  completed-transfer count, wraps at 256
// -----------------------------------------------------------------------------
module reg_share_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [WIDTH-1:0] d0,
   input  logic             req1,
   input  logic [WIDTH-1:0] d1,
   output logic             ack0,
   output logic             ack1,
   output logic             busy,
   output logic             owner,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Qnot,
   output logic [7:0]       xfer_cnt
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      COMMIT  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] hold;
   logic             win;
   logic             start;

`ifdef RR_FAIRNESS_EN
   // Owner of the most recent commit; reset to 1 so requester 0 wins the
   // first tie after reset.
   logic last_owner;
`endif

   // Arbitration and next-state logic. ack and busy are decoded straight
   // from the state register.
   always_comb begin
      win       = 1'b0;
      state_nxt = state;
      ack0      = 1'b0;
      ack1      = 1'b0;
      busy      = 1'b0;
      start     = 1'b0;

      if (req0 && req1) begin
`ifdef RR_FAIRNESS_EN
         win = ~last_owner;
`else
         win = 1'b0;
`endif
      end else if (req1) begin
         win = 1'b1;
      end

      case (state)
         IDLE: begin
            if (req0 || req1) begin
               state_nxt = CAPTURE;
               start     = 1'b1;
            end
         end
         CAPTURE: begin
            busy      = 1'b1;
            state_nxt = COMMIT;
         end
         COMMIT: begin
            busy      = 1'b1;
            ack0      = ~owner;
            ack1      = owner;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         hold     <= '0;
         Q        <= '0;
         owner    <= 1'b1;
         xfer_cnt <= 8'd0;
`ifdef RR_FAIRNESS_EN
         last_owner <= 1'b1;
`endif
      end else begin
         state <= state_nxt;
         if (start) begin
            owner <= win;
            hold  <= win ? d1 : d0;
         end
         if (state == COMMIT) begin
            Q        <= hold;
            xfer_cnt <= xfer_cnt + 8'd1;
`ifdef RR_FAIRNESS_EN
            last_owner <= owner;
`endif
         end
      end
   end

   assign Qnot = ~Q;

endmodule

// File: tb/tb_reg_share_seq.sv
// -----------------------------------------------------------------------------
// tb_reg_share_seq
//   Directed bench for reg_share_seq (WIDTH = 8). Inputs are driven 1 ns after
//   each rising edge, and outputs are sampled at that same point. The expected
//   tie winners depend on RR_FAIRNESS_EN, so the bench should be built with the
//   same macro setting as the design.
// -----------------------------------------------------------------------------
module tb_reg_share_seq;

  localparam int W = 8;

  // clock / reset
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0;
  logic         req1 = 1'b0;
  logic [W-1:0] d0 = '0;
  logic [W-1:0] d1 = '0;
  logic         ack0, ack1, busy, owner;
  logic [W-1:0] q, qnot;
  logic [7:0]   xfer_cnt;

  always #5 clk = ~clk;

  reg_share_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .d0       (d0),
    .req1     (req1),
    .d1       (d1),
    .ack0     (ack0),
    .ack1     (ack1),
    .busy     (busy),
    .owner    (owner),
    .Q        (q),
    .Qnot     (qnot),
    .xfer_cnt (xfer_cnt)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic exp_win;
  int   ack_cnt;
  int   idle_cnt;
  int   ack0_cnt;

  initial begin
    // reset state
    req0 = 1'b0; req1 = 1'b0;
    do_reset();
    check("rst_q", q, 8'h00);
    check("rst_qnot", qnot, 8'hFF);
    check("rst_busy", busy, 1'b0);
    check("rst_ack0", ack0, 1'b0);
    check("rst_ack1", ack1, 1'b0);
    check("rst_owner", owner, 1'b1);
    check("rst_cnt", xfer_cnt, 8'd0);

    // an idle cycle with no request changes nothing
    tick();
    check("idle_busy", busy, 1'b0);
    check("idle_q", q, 8'h00);

    // single transfer from requester 0
    req0 = 1'b1; d0 = 8'hA5;
    tick();                       // edge k
    req0 = 1'b0;
    check("t1_cap_busy", busy, 1'b1);
    check("t1_cap_ack0", ack0, 1'b0);
    check("t1_cap_owner", owner, 1'b0);
    check("t1_cap_q", q, 8'h00);
    tick();                       // edge k+1 -> COMMIT
    check("t1_com_ack0", ack0, 1'b1);
    check("t1_com_ack1", ack1, 1'b0);
    check("t1_com_busy", busy, 1'b1);
    tick();                       // edge k+2 -> IDLE
    check("t1_q", q, 8'hA5);
    check("t1_qnot", qnot, 8'h5A);
    check("t1_cnt", xfer_cnt, 8'd1);
    check("t1_busy", busy, 1'b0);
    check("t1_ack0_off", ack0, 1'b0);

    // four transfers with both requests held
    do_reset();
    d0 = 8'h11; d1 = 8'h22; req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef RR_FAIRNESS_EN
      exp_win = i[0];
`else
      exp_win = 1'b0;
`endif
      exp_q.push_back(exp_win ? 8'h22 : 8'h11);
      tick();
      tick();
      check("tie_ack0", ack0, !exp_win);
      check("tie_ack1", ack1, exp_win);
      tick();
      check("tie_q", q, exp_q.pop_front());
      check("tie_cnt", xfer_cnt, i + 1);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // data changes and request drops after the sampling edge
    req0 = 1'b1; d0 = 8'h3C;
    tick();
    d0 = 8'hFF; req0 = 1'b0;
    tick();
    check("late_ack0", ack0, 1'b1);
    tick();
    check("late_q", q, 8'h3C);
    check("late_ack0_off", ack0, 1'b0);
    tick();
    check("late_no_retry", busy, 1'b0);

    // reset during COMMIT aborts the transfer
    req1 = 1'b1; d1 = 8'h77;
    tick();
    check("abort_owner", owner, 1'b1);
    tick();
    check("abort_com_ack1", ack1, 1'b1);
    rst = 1'b1; req1 = 1'b0;
    tick();
    rst = 1'b0;
    check("abort_ack1", ack1, 1'b0);
    check("abort_q", q, 8'h00);
    check("abort_qnot", qnot, 8'hFF);
    check("abort_cnt", xfer_cnt, 8'd0);
    check("abort_busy", busy, 1'b0);

    // reset takes priority over a request on the same edge
    rst = 1'b1; req0 = 1'b1; d0 = 8'h99;
    tick();
    rst = 1'b0; req0 = 1'b0;
    check("rst_prio_busy", busy, 1'b0);
    tick();
    check("rst_prio_idle", busy, 1'b0);

    // 256 back-to-back transfers from requester 1
    req1 = 1'b1; d1 = 8'h77;
    ack_cnt = 0; idle_cnt = 0; ack0_cnt = 0;
    for (int i = 0; i < 768; i++) begin
      tick();
      if (ack1) ack_cnt++;
      if (ack0) ack0_cnt++;
      if (!busy) idle_cnt++;
      if (i == 764) check("b2b_cnt255", xfer_cnt, 8'd255);
    end
    req1 = 1'b0;
    check("b2b_acks", ack_cnt, 256);
    check("b2b_ack0", ack0_cnt, 0);
    check("b2b_idle", idle_cnt, 256);
    check("b2b_wrap", xfer_cnt, 8'd0);
    check("b2b_q", q, 8'h77);
    check("b2b_qnot", qnot, 8'h88);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
